// File: rtl/mem_ctrl_pkg.sv
// Shared sizing, FSM state type and address range helper for the masked
// 1R1W SRAM controller.
package mem_ctrl_pkg;

  localparam int DEPTH     = 48;
  localparam int WIDTH     = 64;
  localparam int MASK_GRAN = 8;
  localparam int ADDR_W    = $clog2(DEPTH);
  localparam int MASK_W    = WIDTH / MASK_GRAN;

  typedef enum logic {
    CLEAR,
    RUN
  } ctrl_state_e;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return 32'(addr) < 32'(DEPTH);
  endfunction

endpackage

// File: rtl/mem_resp_fifo2.sv
// Two-entry valid/ready FIFO holding read responses until the consumer
// takes them; a simultaneous push and pop is allowed even when full.
module mem_resp_fifo2
  import mem_ctrl_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] slot [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             push;
  logic             pop;

  assign out_valid = (count != 2'd0);
  assign in_ready  = (count != 2'd2) || out_ready;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = slot[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count alone.
  always_ff @(posedge clock) begin
    if (push) slot[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/mem_1r1w_masked_ctrl.sv
// Front-end controller for a byte-masked 1R1W SRAM: zero-fill after reset,
// round-robin write sharing, and a buffered, hazard-safe read port.
module mem_1r1w_masked_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  output logic              init_done,
  input  logic              w0_valid,
  output logic              w0_ready,
  input  logic [ADDR_W-1:0] w0_addr,
  input  logic [WIDTH-1:0]  w0_data,
  input  logic [MASK_W-1:0] w0_mask,
  input  logic              w1_valid,
  output logic              w1_ready,
  input  logic [ADDR_W-1:0] w1_addr,
  input  logic [WIDTH-1:0]  w1_data,
  input  logic [MASK_W-1:0] w1_mask,
  input  logic              r_req_valid,
  output logic              r_req_ready,
  input  logic [ADDR_W-1:0] r_req_addr,
  output logic              r_resp_valid,
  input  logic              r_resp_ready,
  output logic [WIDTH-1:0]  r_resp_data,
  output logic              oob_err,
  output logic [ADDR_W-1:0] mem_W0_addr,
  output logic              mem_W0_en,
  output logic [WIDTH-1:0]  mem_W0_data,
  output logic [MASK_W-1:0] mem_W0_mask,
  output logic [ADDR_W-1:0] mem_R0_addr,
  output logic              mem_R0_en,
  input  logic [WIDTH-1:0]  mem_R0_data
);

  ctrl_state_e       state;
  ctrl_state_e       state_nxt;
  logic [ADDR_W-1:0] clear_cnt;
  logic              rr_ptr;
  logic              run;
  logic              grant0;
  logic              grant1;
  logic              wr_grant;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_in_range;
  logic              rd_in_range;
  logic              hazard;
  logic              r_accept;
  logic              inflight;
  logic              inflight_oob;
  logic              fifo_in_ready;
  logic [1:0]        fifo_count;
  logic              resp_pop;
  logic [1:0]        pending;
  logic [WIDTH-1:0]  fifo_in_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= CLEAR;
      clear_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) clear_cnt <= clear_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == CLEAR && clear_cnt == ADDR_W'(DEPTH - 1)) state_nxt = RUN;
  end

  assign run       = (state == RUN);
  assign init_done = run;

  // rr_ptr == 0 favours w0 on a tie; it flips to the loser after every grant.
  assign grant0   = run && w0_valid && (!w1_valid || !rr_ptr);
  assign grant1   = run && w1_valid && (!w0_valid ||  rr_ptr);
  assign wr_grant = grant0 || grant1;
  assign w0_ready = grant0;
  assign w1_ready = grant1;

  assign wr_addr     = grant1 ? w1_addr : w0_addr;
  assign wr_in_range = addr_in_range(wr_addr);
  assign rd_in_range = addr_in_range(r_req_addr);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr <= 1'b0;
    end else if (grant0) begin
      rr_ptr <= 1'b1;
    end else if (grant1) begin
      rr_ptr <= 1'b0;
    end
  end

  // The clear sweep owns the write port; afterwards the granted requester does.
  always_comb begin
    mem_W0_en   = 1'b0;
    mem_W0_addr = '0;
    mem_W0_data = '0;
    mem_W0_mask = '0;
    if (state == CLEAR) begin
      mem_W0_en   = 1'b1;
      mem_W0_addr = clear_cnt;
      mem_W0_mask = '1;
    end else if (grant1) begin
      mem_W0_en   = wr_in_range;
      mem_W0_addr = w1_addr;
      mem_W0_data = w1_data;
      mem_W0_mask = w1_mask;
    end else if (grant0) begin
      mem_W0_en   = wr_in_range;
      mem_W0_addr = w0_addr;
      mem_W0_data = w0_data;
      mem_W0_mask = w0_mask;
    end
  end

  // Holding the read off while the same word is written makes it return new data.
  assign hazard   = wr_grant && wr_in_range && (wr_addr == r_req_addr);
  assign resp_pop = r_resp_valid && r_resp_ready;
  assign pending  = {1'b0, inflight} + fifo_count - {1'b0, resp_pop};

  assign r_req_ready = run && !hazard && fifo_in_ready && (pending < 2'd2);
  assign r_accept    = r_req_valid && r_req_ready;
  assign mem_R0_en   = r_accept && rd_in_range;
  assign mem_R0_addr = r_req_addr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inflight     <= 1'b0;
      inflight_oob <= 1'b0;
      oob_err      <= 1'b0;
    end else begin
      inflight     <= r_accept;
      inflight_oob <= r_accept && !rd_in_range;
      if ((wr_grant && !wr_in_range) || (r_accept && !rd_in_range)) oob_err <= 1'b1;
    end
  end

  assign fifo_in_data = inflight_oob ? '0 : mem_R0_data;

  mem_resp_fifo2 u_resp_fifo (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (inflight),
    .in_ready  (fifo_in_ready),
    .in_data   (fifo_in_data),
    .out_valid (r_resp_valid),
    .out_ready (r_resp_ready),
    .out_data  (r_resp_data),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_mem_1r1w_masked_ctrl.sv
// Self-checking bench: behavioural SRAM macro plus a transaction-level model
// of expected contents, arbitration and in-order read responses.
module tb_mem_1r1w_masked_ctrl;
  import mem_ctrl_pkg::*;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              init_done;
  logic              w0_valid, w0_ready, w1_valid, w1_ready;
  logic [ADDR_W-1:0] w0_addr, w1_addr, r_req_addr;
  logic [WIDTH-1:0]  w0_data, w1_data;
  logic [MASK_W-1:0] w0_mask, w1_mask;
  logic              r_req_valid, r_req_ready, r_resp_valid, r_resp_ready;
  logic [WIDTH-1:0]  r_resp_data;
  logic              oob_err;
  logic [ADDR_W-1:0] mem_W0_addr, mem_R0_addr;
  logic              mem_W0_en, mem_R0_en;
  logic [WIDTH-1:0]  mem_W0_data, mem_R0_data;
  logic [MASK_W-1:0] mem_W0_mask;

  always #5 clock = ~clock;

  mem_1r1w_masked_ctrl dut (
    .clock(clock), .reset(reset), .init_done(init_done),
    .w0_valid(w0_valid), .w0_ready(w0_ready), .w0_addr(w0_addr), .w0_data(w0_data), .w0_mask(w0_mask),
    .w1_valid(w1_valid), .w1_ready(w1_ready), .w1_addr(w1_addr), .w1_data(w1_data), .w1_mask(w1_mask),
    .r_req_valid(r_req_valid), .r_req_ready(r_req_ready), .r_req_addr(r_req_addr),
    .r_resp_valid(r_resp_valid), .r_resp_ready(r_resp_ready), .r_resp_data(r_resp_data),
    .oob_err(oob_err),
    .mem_W0_addr(mem_W0_addr), .mem_W0_en(mem_W0_en), .mem_W0_data(mem_W0_data), .mem_W0_mask(mem_W0_mask),
    .mem_R0_addr(mem_R0_addr), .mem_R0_en(mem_R0_en), .mem_R0_data(mem_R0_data)
  );

  // Behavioural macro: masked write, one-cycle registered read.
  logic [WIDTH-1:0] sram [2**ADDR_W];
  logic [WIDTH-1:0] sram_rdata;
  always @(posedge clock) begin
    if (mem_W0_en)
      for (int l = 0; l < MASK_W; l++)
        if (mem_W0_mask[l]) sram[mem_W0_addr][l*MASK_GRAN +: MASK_GRAN] <= mem_W0_data[l*MASK_GRAN +: MASK_GRAN];
    if (mem_R0_en) sram_rdata <= sram[mem_R0_addr];
  end
  assign mem_R0_data = sram_rdata;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               acc;
  } exp_t;

  logic [WIDTH-1:0] ref_mem [DEPTH];
  bit               ref_oob;
  bit               rr_w1;
  exp_t             q[$];
  int               cyc;
  int               checks;
  int               errors;
  int               resp_cnt;
  bit               last_w0_acc, last_w1_acc, last_r_acc, last_r_ready, last_resp;
  logic [WIDTH-1:0] last_resp_data;

  function automatic logic [WIDTH-1:0] apply_mask(input logic [WIDTH-1:0] old_v,
                                                  input logic [WIDTH-1:0] new_v,
                                                  input logic [MASK_W-1:0] mask);
    logic [WIDTH-1:0] r;
    r = old_v;
    for (int l = 0; l < MASK_W; l++)
      if (mask[l]) r[l*MASK_GRAN +: MASK_GRAN] = new_v[l*MASK_GRAN +: MASK_GRAN];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic observe();
    bit               g0, g1, winr, rinr, rv, pop, haz, exp_rdy, acc;
    logic [ADDR_W-1:0] waddr;
    logic [WIDTH-1:0]  wdata;
    logic [MASK_W-1:0] wmask;
    last_w0_acc = 0; last_w1_acc = 0; last_r_acc = 0; last_resp = 0;
    last_r_ready = r_req_ready;
    if (cyc < DEPTH) begin
      chk("clr_en", mem_W0_en, 1);
      chk("clr_addr", mem_W0_addr, 64'(cyc));
      chk("clr_data", mem_W0_data, 0);
      chk("clr_mask", mem_W0_mask, 8'hFF);
      chk("clr_w0_ready", w0_ready, 0);
      chk("clr_w1_ready", w1_ready, 0);
      chk("clr_r_req_ready", r_req_ready, 0);
      chk("clr_init_done", init_done, 0);
      chk("clr_resp_valid", r_resp_valid, 0);
      return;
    end
    chk("init_done", init_done, 1);
    chk("oob_err", oob_err, ref_oob);
    g0 = w0_valid && (!w1_valid || !rr_w1);
    g1 = w1_valid && (!w0_valid || rr_w1);
    chk("w0_ready", w0_ready, g0);
    chk("w1_ready", w1_ready, g1);
    waddr = g1 ? w1_addr : w0_addr;
    wdata = g1 ? w1_data : w0_data;
    wmask = g1 ? w1_mask : w0_mask;
    winr  = int'(waddr) < DEPTH;
    chk("w_en", mem_W0_en, (g0 || g1) && winr);
    if ((g0 || g1) && winr) begin
      chk("w_addr", mem_W0_addr, waddr);
      chk("w_data", mem_W0_data, wdata);
      chk("w_mask", mem_W0_mask, wmask);
    end
    rv = (q.size() > 0) && (cyc >= q[0].acc + 2);
    chk("resp_valid", r_resp_valid, rv);
    if (rv) chk("resp_data", r_resp_data, q[0].data);
    pop     = rv && r_resp_ready;
    haz     = (g0 || g1) && winr && (waddr == r_req_addr);
    exp_rdy = !haz && ((q.size() - int'(pop)) < 2);
    chk("r_req_ready", r_req_ready, exp_rdy);
    acc  = r_req_valid && exp_rdy;
    rinr = int'(r_req_addr) < DEPTH;
    chk("r_en", mem_R0_en, acc && rinr);
    if (acc && rinr) chk("r_addr", mem_R0_addr, r_req_addr);
    if (pop) begin
      last_resp      = 1;
      last_resp_data = q[0].data;
      resp_cnt++;
      void'(q.pop_front());
    end
    if (acc) q.push_back('{rinr ? ref_mem[r_req_addr] : '0, cyc});
    if (acc && !rinr) ref_oob = 1;
    if (g0 || g1) begin
      if (winr) ref_mem[waddr] = apply_mask(ref_mem[waddr], wdata, wmask);
      else ref_oob = 1;
      rr_w1 = g0;
    end
    last_w0_acc = g0;
    last_w1_acc = g1;
    last_r_acc  = acc;
  endtask

  task automatic tick();
    @(negedge clock);
    observe();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic applyStimulus_reset();
    w0_valid = 0; w1_valid = 0; r_req_valid = 0; r_resp_ready = 1;
    reset = 1;
    #1;
    chk("rst_init_done", init_done, 0);
    chk("rst_oob_err", oob_err, 0);
    chk("rst_w0_ready", w0_ready, 0);
    chk("rst_w1_ready", w1_ready, 0);
    chk("rst_r_req_ready", r_req_ready, 0);
    chk("rst_resp_valid", r_resp_valid, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 0;
    cyc = 0;
    ref_oob = 0;
    rr_w1 = 0;
    q.delete();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  task automatic applyStimulus_write(input bit port, input logic [ADDR_W-1:0] a,
                                     input logic [WIDTH-1:0] d, input logic [MASK_W-1:0] m);
    bit done = 0;
    if (port) begin w1_valid = 1; w1_addr = a; w1_data = d; w1_mask = m; end
    else      begin w0_valid = 1; w0_addr = a; w0_data = d; w0_mask = m; end
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      done = port ? last_w1_acc : last_w0_acc;
    end
    w0_valid = 0; w1_valid = 0;
    chk("write_accept", done, 1);
  endtask

  task automatic applyStimulus_read(input logic [ADDR_W-1:0] a);
    bit done = 0;
    r_req_valid = 1; r_req_addr = a;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      done = last_r_acc;
    end
    r_req_valid = 0;
    chk("read_accept", done, 1);
  endtask

  task automatic checkOutput_response(input string tag, input logic [WIDTH-1:0] exp);
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = last_resp;
    end
    chk({tag, "_arrived"}, got, 1);
    chk(tag, last_resp_data, exp);
  endtask

  initial begin
    int next_addr;
    int acc_cnt;
    int base;
    checks = 0; errors = 0; resp_cnt = 0; cyc = 0;
    w0_valid = 0; w1_valid = 0; r_req_valid = 0; r_resp_ready = 1;
    w0_addr = 0; w1_addr = 0; r_req_addr = 0;
    w0_data = 0; w1_data = 0; w0_mask = 0; w1_mask = 0;
    #2;
    applyStimulus_reset();

    // Both writers wait through the clear sweep, then should alternate.
    w0_valid = 1; w0_addr = 1; w0_data = 64'h0101; w0_mask = '1;
    w1_valid = 1; w1_addr = 2; w1_data = 64'h0202; w1_mask = '1;
    repeat (DEPTH) tick();
    for (int i = 0; i < 6; i++) begin
      w0_addr = ADDR_W'(10 + i); w0_data = {$urandom, $urandom};
      w1_addr = ADDR_W'(20 + i); w1_data = {$urandom, $urandom};
      tick();
      chk("alt_grant", {last_w0_acc, last_w1_acc}, (i % 2 == 0) ? 2'b10 : 2'b01);
    end
    w0_valid = 0; w1_valid = 0;

    applyStimulus_write(0, 5, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
    applyStimulus_write(1, 5, 64'h1122334455667788, 8'h0F);
    applyStimulus_read(5);
    checkOutput_response("mask_merge", 64'hFFFFFFFF55667788);

    w0_valid = 1; w0_addr = 7; w0_data = 64'hA5A5A5A5A5A5A5A5; w0_mask = 8'hFF;
    r_req_valid = 1; r_req_addr = 7;
    tick();
    chk("hazard_block", last_r_ready, 0);
    chk("hazard_write", last_w0_acc, 1);
    w0_valid = 0;
    tick();
    chk("hazard_issue", last_r_acc, 1);
    r_req_valid = 0;
    checkOutput_response("hazard_data", 64'hA5A5A5A5A5A5A5A5);

    for (int i = 0; i < 400; i++) begin
      w0_valid = ($urandom_range(0, 2) != 0);
      w1_valid = ($urandom_range(0, 2) != 0);
      w0_addr = ADDR_W'($urandom_range(0, DEPTH - 1)); w0_data = {$urandom, $urandom}; w0_mask = MASK_W'($urandom);
      w1_addr = ADDR_W'($urandom_range(0, DEPTH - 1)); w1_data = {$urandom, $urandom}; w1_mask = MASK_W'($urandom);
      r_req_valid  = ($urandom_range(0, 1) != 0);
      r_req_addr   = ADDR_W'($urandom_range(0, DEPTH - 1));
      r_resp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    w0_valid = 0; w1_valid = 0; r_req_valid = 0; r_resp_ready = 1;
    repeat (6) tick();
    chk("drain_empty", q.size(), 0);

    // Streamed reads against a stalled consumer, then released.
    base = resp_cnt;
    next_addr = 0;
    acc_cnt = 0;
    r_resp_ready = 0;
    r_req_valid = 1;
    repeat (5) begin
      r_req_addr = ADDR_W'(next_addr);
      tick();
      if (last_r_acc) begin next_addr++; acc_cnt++; end
    end
    chk("stall_accepts", acc_cnt, 2);
    r_resp_ready = 1;
    for (int i = 0; i < 60 && (next_addr < 10 || q.size() > 0); i++) begin
      r_req_valid = (next_addr < 10);
      r_req_addr  = ADDR_W'(next_addr);
      tick();
      if (last_r_acc) next_addr++;
    end
    r_req_valid = 0;
    chk("stream_resps", resp_cnt - base, 10);

    w1_valid = 1; w1_addr = 50; w1_data = 64'hDEADBEEFDEADBEEF; w1_mask = 8'hFF;
    tick();
    chk("oob_wr_accept", last_w1_acc, 1);
    w1_valid = 0;
    tick();
    chk("oob_flag", oob_err, 1);
    applyStimulus_read(60);
    checkOutput_response("oob_rdata", 64'h0);
    repeat (5) tick();
    chk("oob_sticky", oob_err, 1);

    applyStimulus_reset();
    repeat (20) tick();
    chk("clr_at_20", mem_W0_addr, 20);
    applyStimulus_reset();
    repeat (DEPTH) tick();
    repeat (3) tick();
    chk("init_after_restart", init_done, 1);
    chk("oob_cleared", oob_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
